// File: rtl/mprj_io_cfg_loader.sv
// Serial configuration loader: fetches one word per pad and shifts it MSB-first down the GPIO chain.
// Optional build macro MPRJ_IO_CFG_CLKDIV_EN adds the clkdiv input that stretches shift and load phases.
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module mprj_io_cfg_loader #(
    parameter int TOTAL_PADS = `MPRJ_IO_PADS,
    parameter int CFG_BITS   = 13,
    parameter int AW         = 6
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    output logic                cfg_rd,
    output logic [AW-1:0]       cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_data,
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load,
    output logic                busy,
    output logic                done
`ifdef MPRJ_IO_CFG_CLKDIV_EN
    ,
    input  logic [3:0]          clkdiv
`endif
);

    // start is a one-cycle request honoured only in IDLE; cfg_data answers cfg_rd one cycle later.
    localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam logic [AW-1:0] PAD_LAST = AW'(TOTAL_PADS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(CFG_BITS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        CAPTURE  = 3'd2,
        SHIFT_LO = 3'd3,
        SHIFT_HI = 3'd4,
        LOAD     = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t              state, state_n;
    logic [AW-1:0]       pad_cnt, pad_n;
    logic [BW-1:0]       bit_cnt, bit_n;
    logic [3:0]          div_cnt, div_n;
    logic [3:0]          div_q;
    logic                load_cnt, load_n;
    logic [CFG_BITS-1:0] shreg, shreg_n;
    logic                sdata_n;

    logic cfg_rd_n, sclk_n, sload_n, busy_n, done_n;

`ifdef MPRJ_IO_CFG_CLKDIV_EN
    always_ff @(posedge clock) begin
        if (!resetn) begin
            div_q <= 4'd0;
        end else if (state == IDLE && start) begin
            div_q <= clkdiv;
        end
    end
`else
    assign div_q = 4'd0;
`endif

    always_comb begin
        state_n = state;
        pad_n   = pad_cnt;
        bit_n   = bit_cnt;
        div_n   = div_cnt;
        load_n  = load_cnt;
        shreg_n = shreg;
        sdata_n = serial_data;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = FETCH;
                    pad_n   = PAD_LAST;
                    bit_n   = '0;
                    div_n   = '0;
                end
            end
            FETCH: begin
                state_n = CAPTURE;
            end
            CAPTURE: begin
                state_n = SHIFT_LO;
                shreg_n = cfg_data;
                sdata_n = cfg_data[CFG_BITS-1];
                bit_n   = '0;
                div_n   = '0;
            end
            SHIFT_LO: begin
                if (div_cnt == div_q) begin
                    div_n   = '0;
                    state_n = SHIFT_HI;
                    shreg_n = shreg << 1;
                end else begin
                    div_n = div_cnt + 4'd1;
                end
            end
            SHIFT_HI: begin
                // shreg already moved on entry to this phase, so its MSB is the next bit
                if (div_cnt == div_q) begin
                    div_n = '0;
                    if (bit_cnt == BIT_LAST) begin
                        if (pad_cnt == '0) begin
                            state_n = LOAD;
                            load_n  = 1'b0;
                        end else begin
                            state_n = FETCH;
                            pad_n   = pad_cnt - AW'(1);
                        end
                    end else begin
                        state_n = SHIFT_LO;
                        bit_n   = bit_cnt + BW'(1);
                        sdata_n = shreg[CFG_BITS-1];
                    end
                end else begin
                    div_n = div_cnt + 4'd1;
                end
            end
            LOAD: begin
                if (div_cnt == div_q) begin
                    div_n = '0;
                    if (load_cnt) begin
                        state_n = DONE;
                    end else begin
                        load_n = 1'b1;
                    end
                end else begin
                    div_n = div_cnt + 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    assign cfg_rd_n = (state_n == FETCH);
    assign sclk_n   = (state_n == SHIFT_HI);
    assign sload_n  = (state_n == LOAD);
    assign done_n   = (state_n == DONE);
    assign busy_n   = (state_n != IDLE) && (state_n != DONE);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state        <= IDLE;
            pad_cnt      <= '0;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            load_cnt     <= 1'b0;
            shreg        <= '0;
            cfg_rd       <= 1'b0;
            cfg_addr     <= '0;
            serial_clock <= 1'b0;
            serial_data  <= 1'b0;
            serial_load  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            pad_cnt      <= pad_n;
            bit_cnt      <= bit_n;
            div_cnt      <= div_n;
            load_cnt     <= load_n;
            shreg        <= shreg_n;
            cfg_rd       <= cfg_rd_n;
            cfg_addr     <= pad_n;
            serial_clock <= sclk_n;
            serial_data  <= sdata_n;
            serial_load  <= sload_n;
            busy         <= busy_n;
            done         <= done_n;
        end
    end

endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// Bench for mprj_io_cfg_loader: a small (2x4) and a default (38x13) instance checked against a timeline model.
module tb_mprj_io_cfg_loader;

`ifdef MPRJ_IO_CFG_CLKDIV_EN
    localparam int DIV_S      = 3;
    localparam int SMALL_DONE = 76;
    localparam int SMALL_LOAD = 8;
`else
    localparam int DIV_S      = 0;
    localparam int SMALL_DONE = 22;
    localparam int SMALL_LOAD = 2;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic resetn, start_s, start_d;
    logic       cfg_rd_s, sclk_s, sdata_s, sload_s, busy_s, done_s;
    logic [5:0] cfg_addr_s;
    logic [3:0] cfg_data_s = '0;
    logic       cfg_rd_d, sclk_d, sdata_d, sload_d, busy_d, done_d;
    logic [5:0] cfg_addr_d;
    logic [12:0] cfg_data_d = '0;

    mprj_io_cfg_loader #(.TOTAL_PADS(2), .CFG_BITS(4), .AW(6)) dut_s (
        .clock(clock), .resetn(resetn), .start(start_s),
        .cfg_rd(cfg_rd_s), .cfg_addr(cfg_addr_s), .cfg_data(cfg_data_s),
        .serial_clock(sclk_s), .serial_data(sdata_s), .serial_load(sload_s),
        .busy(busy_s), .done(done_s)
`ifdef MPRJ_IO_CFG_CLKDIV_EN
        , .clkdiv(4'(DIV_S))
`endif
    );

    mprj_io_cfg_loader dut_d (
        .clock(clock), .resetn(resetn), .start(start_d),
        .cfg_rd(cfg_rd_d), .cfg_addr(cfg_addr_d), .cfg_data(cfg_data_d),
        .serial_clock(sclk_d), .serial_data(sdata_d), .serial_load(sload_d),
        .busy(busy_d), .done(done_d)
`ifdef MPRJ_IO_CFG_CLKDIV_EN
        , .clkdiv(4'd0)
`endif
    );

    // Config stores: registered read, data valid the cycle after cfg_rd.
    logic [12:0] mem_s [2];
    logic [12:0] mem_d [38];
    always @(posedge clock) begin
        if (cfg_rd_s) cfg_data_s <= mem_s[cfg_addr_s][3:0];
        if (cfg_rd_d) cfg_data_d <= mem_d[cfg_addr_d];
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;

    // Timeline model: offset tt cycles after the accepting edge fixes every output.
    int tp [2] = '{2, 38};
    int cb [2] = '{4, 13};
    int ln [2] = '{DIV_S + 1, 1};
    bit act [2] = '{0, 0};
    int tt  [2] = '{0, 0};

    function automatic int pad_len(int i);
        return 2 + 2 * cb[i] * ln[i];
    endfunction

    function automatic int busy_len(int i);
        return tp[i] * pad_len(i) + 2 * ln[i];
    endfunction

    always @(posedge clock) begin
        logic st;
        for (int i = 0; i < 2; i++) begin
            st = (i == 0) ? start_s : start_d;
            if (!resetn) act[i] = 0;
            else if (st && (!act[i] || tt[i] > busy_len(i))) begin
                act[i] = 1;
                tt[i]  = 0;
            end else if (act[i]) tt[i]++;
        end
    end

    typedef struct packed {
        logic       busy;
        logic       rd;
        logic [5:0] addr;
        logic       sclk;
        logic       chk;
        logic       data;
        logic       sload;
        logic       done;
    } exp_t;

    function automatic exp_t expect_at(int i);
        exp_t e;
        int t, p, o, q, b;
        logic [12:0] w;
        e = '0;
        if (!act[i]) return e;
        t = tt[i];
        if (t < tp[i] * pad_len(i)) begin
            p = t / pad_len(i);
            o = t % pad_len(i);
            e.busy = 1'b1;
            e.addr = 6'(tp[i] - 1 - p);
            e.rd   = (o == 0);
            if (o >= 2) begin
                q = o - 2;
                b = q / (2 * ln[i]);
                e.sclk = ((q % (2 * ln[i])) >= ln[i]);
                w = (i == 0) ? mem_s[tp[i] - 1 - p] : mem_d[tp[i] - 1 - p];
                e.chk  = 1'b1;
                e.data = w[cb[i] - 1 - b];
            end
        end else if (t < busy_len(i)) begin
            e.busy  = 1'b1;
            e.sload = 1'b1;
        end else if (t == busy_len(i)) begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    // Per-cycle compare of both instances against the model.
    initial begin
        exp_t e;
        logic a_busy, a_rd, a_sclk, a_sd, a_sload, a_done;
        logic [5:0] a_addr;
        logic prev_sd [2];
        bit ok;
        forever begin
            @(negedge clock);
            if (cmp_en) begin
                for (int i = 0; i < 2; i++) begin
                    e       = expect_at(i);
                    a_busy  = (i == 0) ? busy_s   : busy_d;
                    a_rd    = (i == 0) ? cfg_rd_s : cfg_rd_d;
                    a_addr  = (i == 0) ? cfg_addr_s : cfg_addr_d;
                    a_sclk  = (i == 0) ? sclk_s   : sclk_d;
                    a_sd    = (i == 0) ? sdata_s  : sdata_d;
                    a_sload = (i == 0) ? sload_s  : sload_d;
                    a_done  = (i == 0) ? done_s   : done_d;
                    ok = (a_busy === e.busy) && (a_rd === e.rd) && (a_addr === e.addr) &&
                         (a_sclk === e.sclk) && (a_sload === e.sload) && (a_done === e.done) &&
                         (!e.chk || a_sd === e.data) && (!a_sclk || a_sd === prev_sd[i]);
                    n_tests++;
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL cycle_model inst=%0d t=%0d got busy=%b rd=%b addr=%0d sclk=%b sd=%b load=%b done=%b want busy=%b rd=%b addr=%0d sclk=%b sd=%b(chk=%b, held=%b) load=%b done=%b",
                                 i, tt[i], a_busy, a_rd, a_addr, a_sclk, a_sd, a_sload, a_done,
                                 e.busy, e.rd, e.addr, e.sclk, e.data, e.chk, prev_sd[i], e.sload, e.done);
                    end
                    prev_sd[i] = a_sd;
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // One default-size sequence: chain model, cfg_rd/cfg_addr log, busy/done timing.
    task automatic run_default(input int restart_at, input int reset_at);
        logic [38*13-1:0] chain, latched;
        logic [5:0] exp_a [$];
        logic [5:0] got_a [$];
        int busy_cnt, done_k, k;
        bit got_load, prev_sclk, bad;
        chain = '0; latched = '0; busy_cnt = 0; done_k = -1;
        got_load = 0; prev_sclk = 0;
        for (int p = 0; p < 38; p++) mem_d[p] = 13'($urandom_range(0, 8191));
        start_d = 1'b1;
        @(negedge clock);
        start_d = 1'b0;
        for (k = 0; k < 1200; k++) begin
            if (busy_d) busy_cnt++;
            if (cfg_rd_d) got_a.push_back(cfg_addr_d);
            if (sclk_d && !prev_sclk) chain = {chain[38*13-2:0], sdata_d};
            if (sload_d && !got_load) begin
                latched  = chain;
                got_load = 1;
            end
            if (done_d && done_k < 0) done_k = k;
            prev_sclk = sclk_d;
            start_d = (k == restart_at);
            if (k == reset_at) begin
                resetn = 1'b0;
                @(negedge clock);
                resetn = 1'b1;
                check("reset_busy", int'(busy_d), 0);
                check("reset_sclk", int'(sclk_d), 0);
                check("reset_load", int'(sload_d), 0);
                check("reset_done", int'(done_d), 0);
                bad = 0;
                repeat (20) begin
                    @(negedge clock);
                    if (sload_d || done_d || busy_d) bad = 1;
                end
                check("reset_quiet", int'(bad), 0);
                return;
            end
            if (done_k >= 0 && k >= done_k + 3) break;
            @(negedge clock);
        end
        start_d = 1'b0;
        check("default_done_offset", done_k, 1066);
        check("default_busy_cycles", busy_cnt, 1066);
        check("default_cfg_rd_count", got_a.size(), 38);
        for (int p = 37; p >= 0; p--) exp_a.push_back(6'(p));
        while (exp_a.size() > 0 && got_a.size() > 0)
            check("cfg_addr_step", int'(got_a.pop_front()), int'(exp_a.pop_front()));
        for (int p = 0; p < 38; p++)
            check($sformatf("chain_pad%0d", p), int'(latched[13*p +: 13]), int'(mem_d[p]));
    endtask

    initial begin
        logic [0:0] exp_q [$];
        logic [0:0] got_q [$];
        int k, done_k, load_cnt;
        bit prev_sclk, idle_bad;

        resetn = 1'b0; start_s = 1'b0; start_d = 1'b0;
        mem_s[0] = '0; mem_s[1] = '0;
        for (int p = 0; p < 38; p++) mem_d[p] = '0;
        repeat (3) @(negedge clock);
        cmp_en = 1;
        check("reset_outputs_small", int'({busy_s, cfg_rd_s, cfg_addr_s, sclk_s, sdata_s, sload_s, done_s}), 0);
        check("reset_outputs_default", int'({busy_d, cfg_rd_d, cfg_addr_d, sclk_d, sdata_d, sload_d, done_d}), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        // Small chain: pad1 = A, pad0 = 5; a start during the DONE cycle must be dropped.
        mem_s[1] = 13'h00A;
        mem_s[0] = 13'h005;
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        done_k = -1; load_cnt = 0; prev_sclk = 0; idle_bad = 0;
        start_s = 1'b1;
        @(negedge clock);
        start_s = 1'b0;
        for (k = 0; k < 200; k++) begin
            if (sclk_s && !prev_sclk) got_q.push_back(sdata_s);
            prev_sclk = sclk_s;
            if (sload_s) load_cnt++;
            if (done_k >= 0 && k > done_k && busy_s) idle_bad = 1;
            if (done_s && done_k < 0) begin
                done_k  = k;
                start_s = 1'b1;
            end else begin
                start_s = 1'b0;
            end
            if (done_k >= 0 && k >= done_k + 10) break;
            @(negedge clock);
        end
        start_s = 1'b0;
        check("small_done_offset", done_k, SMALL_DONE);
        check("small_load_cycles", load_cnt, SMALL_LOAD);
        check("small_bit_count", got_q.size(), 8);
        while (exp_q.size() > 0 && got_q.size() > 0)
            check("small_bit", int'(got_q.pop_front()), int'(exp_q.pop_front()));
        check("start_in_done_ignored", int'(idle_bad), 0);

        run_default(100, -1);
        repeat (3) @(negedge clock);
        run_default(-1, 50);
        repeat (3) @(negedge clock);
        run_default(-1, -1);
        repeat (5) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mprj_io_cfg_loader.md
# mprj_io_cfg_loader

Serial configuration loader feeding the user-project GPIO pad array. On request it fetches one configuration word per pad from a local config store, shifts the words bit-serially down the GPIO control-block chain, then pulses a load strobe. The chain outputs then drive the pad array's per-pad `oeb`, `inp_dis`, `dm` and related control inputs.

## Interface
Parameters:
- `TOTAL_PADS`, default `` `MPRJ_IO_PADS `` (38): number of pads in the chain.
- `CFG_BITS`, default 13: configuration bits per pad.
- `AW`, default 6: width of `cfg_addr`. Must satisfy 2^AW >= TOTAL_PADS.

Ports:
- `clock`  in  1  core clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle request to (re)load the entire chain.
- `cfg_rd`  out  1  read strobe to the config store.
- `cfg_addr`  out  AW  pad index being read.
- `cfg_data`  in  CFG_BITS  config word. Valid the cycle after `cfg_rd`.
- `serial_clock`  out  1  chain shift clock; the chain samples on its rising edge.
- `serial_data`  out  1  chain data; changes only while `serial_clock` is low.
- `serial_load`  out  1  chain latch strobe.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle completion pulse.
- `clkdiv`  in  4  phase stretch. Present only with `MPRJ_IO_CFG_CLKDIV_EN`.

## Operation
- Reset values: all outputs 0 (`cfg_addr` = 0, `serial_clock` = 0, `busy` = 0). Internal counters and the shift register also clear to 0.
- FSM states and transitions:
  - IDLE → FETCH when `start` = 1.
  - FETCH: `cfg_rd` = 1 for one cycle. `cfg_addr` = current pad index.
  - CAPTURE: `cfg_data` is latched into the shift register.
  - SHIFT_LO: `serial_clock` = 0; `serial_data` = current MSB.
  - SHIFT_HI: `serial_clock` = 1; shift register moves left by 1.
  - After CFG_BITS bit pairs: go to FETCH for the next pad, or to LOAD after the last pad.
  - LOAD: `serial_load` = 1 for 2 cycles.
  - DONE: `done` = 1 for 1 cycle, `busy` = 0, then IDLE.
- Pad order: pad TOTAL_PADS-1 first, down to pad 0 last, so pad 0's word ends nearest the chain input. Bit order within a word: MSB first.
- `busy` is 1 in every state except IDLE and DONE.
- `start` while `busy` = 1 is ignored and is not queued. `start` in the DONE cycle is also ignored.
- The pad counter decrements from TOTAL_PADS-1 and terminates at 0 with no wrap. The bit counter runs 0..CFG_BITS-1.
- `resetn` low mid-sequence: every output returns to its reset value at the next edge. No `serial_load` is issued, and the chain contents are undefined until the next full load.

## Timing
- Without the macro, each bit takes 2 cycles and each pad takes 2 + 2·CFG_BITS cycles.
- `start` sampled at edge 0 → `busy` = 1 and `cfg_rd` = 1 from edge 1.
- First `serial_data` bit valid at edge 3; first `serial_clock` rise at edge 4.
- `busy` stays high for TOTAL_PADS·(2+2·CFG_BITS)+2 cycles. With defaults this is 1066 cycles.
- `done` goes high in the first cycle with `busy` = 0.
- `serial_data` is held stable through the SHIFT_HI cycle, giving one full cycle of setup and one of hold around each `serial_clock` rise.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MPRJ_IO_CFG_CLKDIV_EN` defined:
  - Port `clkdiv` exists. It is sampled when `start` is accepted and held for the whole sequence.
  - SHIFT_LO and SHIFT_HI each last `clkdiv`+1 cycles.
  - Each LOAD cycle is stretched the same way.
  - `clkdiv` = 0 gives timing identical to the macro-undefined build.
- Undefined: no `clkdiv` port; each shift phase and each LOAD cycle is exactly 1 cycle.

## Test plan
- TOTAL_PADS=2, CFG_BITS=4, cfg store {pad1 = 4'hA, pad0 = 4'h5}, `start` pulse → bits sampled on `serial_clock` rises are 1,0,1,0,0,1,0,1. Then `serial_load` is high for 2 cycles, and `done` pulses 22 cycles after `start`.
- Default parameters with a random store → a 38×13 shift-register model of the chain matches the store after `serial_load`. `busy` is high for exactly 1066 cycles.
- `start` reasserted at cycle 100 of a sequence → no restart; `done` still pulses at the original cycle; exactly 38 `cfg_rd` pulses occur.
- `resetn` low at cycle 50 → the next edge shows `busy` = 0, `serial_clock` = 0, no `serial_load`, no `done`. A fresh `start` then completes normally.
- `cfg_addr` checks → `cfg_addr` steps 37, 36, …, 0, one value per `cfg_rd`. `serial_data` never changes while `serial_clock` = 1.
- With `MPRJ_IO_CFG_CLKDIV_EN`, `clkdiv` = 3, TOTAL_PADS=2, CFG_BITS=4 → each `serial_clock` phase lasts 4 cycles, `serial_load` is high for 8 cycles, and `done` pulses 2·(2+8·4)+8 = 76 cycles after `start`.
